// File: rtl/prirv32_lsu_ctrl.sv
// priRV32 load/store sequencer: computes the effective address, checks op/alignment,
// runs one valid/ready bus transaction and returns extended load data to writeback.
module prirv32_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic [7:0]  ls_op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm_val,
  input  logic [4:0]  rd_idx,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        ls_done,
  output logic        err_misalign,
  output logic        err_illegal,
  output logic        err_bus,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [31:0]       ea_q, rs2_q, err_addr_q, wb_data_q;
  logic [7:0]        op_q;
  logic [4:0]        rd_q, wb_rd_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [31:0] ea_in;
  logic        accept, op_onehot, in_half, in_word, in_misalign;
  logic        is_load, timeout_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_res, st_wdata;
  logic [3:0]  st_strb;

  assign ea_in       = rs1_val + imm_val;
  assign accept      = ls_valid && (state == IDLE);
  assign op_onehot   = (ls_op != 8'd0) && ((ls_op & (ls_op - 8'd1)) == 8'd0);
  assign in_half     = ls_op[6] | ls_op[3] | ls_op[1];
  assign in_word     = ls_op[5] | ls_op[0];
  assign in_misalign = (in_half && ea_in[0]) || (in_word && (ea_in[1:0] != 2'b00));
  assign is_load     = |op_q[7:3];
  // Ready arriving on the last allowed cycle takes priority over the timeout.
  assign timeout_hit = TO_EN && (state == BUS) && !mem_ready && (cnt_q == TO_LAST);

  always_comb begin
    case (ea_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = ea_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_res = mem_rdata;
    if (op_q[7])      load_res = {{24{byte_sel[7]}}, byte_sel};
    else if (op_q[6]) load_res = {{16{half_sel[15]}}, half_sel};
    else if (op_q[4]) load_res = {24'd0, byte_sel};
    else if (op_q[3]) load_res = {16'd0, half_sel};
  end

  always_comb begin
    st_strb  = 4'b0000;
    st_wdata = 32'd0;
    if (op_q[2]) begin
      st_strb  = 4'b0001 << ea_q[1:0];
      st_wdata = {4{rs2_q[7:0]}};
    end else if (op_q[1]) begin
      st_strb  = 4'b0011 << ea_q[1:0];
      st_wdata = {2{rs2_q[15:0]}};
    end else if (op_q[0]) begin
      st_strb  = 4'b1111;
      st_wdata = rs2_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (!op_onehot || in_misalign) ? ERR : BUS;
      BUS: begin
        if (mem_ready)        state_nxt = RESP;
        else if (timeout_hit) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ls_ready     = (state == IDLE);
    mem_valid    = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_wstrb    = 4'b0000;
    wb_valid     = 1'b0;
    ls_done      = 1'b0;
    err_misalign = 1'b0;
    err_illegal  = 1'b0;
    err_bus      = 1'b0;
    case (state)
      BUS: begin
        mem_valid = 1'b1;
        mem_addr  = {ea_q[31:2], 2'b00};
        mem_wdata = st_wdata;
        mem_wstrb = st_strb;
        err_bus   = timeout_hit;
        ls_done   = timeout_hit;
      end
      RESP: begin
        ls_done  = 1'b1;
        wb_valid = is_load && (rd_q != 5'd0);
      end
      ERR: begin
        ls_done      = 1'b1;
        err_illegal  = illegal_q;
        err_misalign = !illegal_q;
      end
      default: ;
    endcase
  end

  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign err_addr = ((state == ERR) || timeout_hit) ? ea_q : err_addr_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ea_q       <= 32'd0;
      rs2_q      <= 32'd0;
      op_q       <= 8'd0;
      rd_q       <= 5'd0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
      err_addr_q <= 32'd0;
      wb_data_q  <= 32'd0;
      wb_rd_q    <= 5'd0;
    end else begin
      if (accept) begin
        ea_q      <= ea_in;
        rs2_q     <= rs2_val;
        op_q      <= ls_op;
        rd_q      <= rd_idx;
        illegal_q <= !op_onehot;
      end
      if (state == BUS) begin
        if (mem_ready || timeout_hit) cnt_q <= '0;
        else                          cnt_q <= cnt_q + CNT_W'(1);
        if (mem_ready && is_load) begin
          wb_data_q <= load_res;
          wb_rd_q   <= rd_q;
        end
      end
      if ((state == ERR) || timeout_hit) err_addr_q <= ea_q;
    end
  end

endmodule

// File: tb/tb_prirv32_lsu_ctrl.sv
// Self-checking bench for prirv32_lsu_ctrl: directed vector table, a mid-bus reset
// sequence, and randomized transactions checked against a byte-level reference model.
module tb_prirv32_lsu_ctrl;

  localparam int TO = 4;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        ls_valid, ls_ready;
  logic [7:0]  ls_op;
  logic [31:0] rs1_val, rs2_val, imm_val;
  logic [4:0]  rd_idx;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ls_done, err_misalign, err_illegal, err_bus;
  logic [31:0] err_addr;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_err_addr = 32'd0;
  logic [31:0] last_wb_data  = 32'd0;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] rs1, imm, rs2, rdata;
    logic [4:0]  rd;
    int          delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    int          exp_err;   // 0 ok, 1 misalign, 2 illegal, 3 bus timeout
  } vec_t;

  vec_t vecs[$];

  prirv32_lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_op(ls_op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm_val(imm_val), .rd_idx(rd_idx),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .ls_done(ls_done),
    .err_misalign(err_misalign), .err_illegal(err_illegal), .err_bus(err_bus),
    .err_addr(err_addr)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(string nm, logic [7:0] op, logic [31:0] rs1, logic [31:0] imm,
                              logic [31:0] rs2, logic [31:0] rdata, logic [4:0] rd, int delay,
                              logic [31:0] ea_exp, logic [3:0] strb, logic [31:0] wdata,
                              logic [31:0] data, int err);
    vec_t v;
    v.name = nm; v.op = op; v.rs1 = rs1; v.imm = imm; v.rs2 = rs2; v.rdata = rdata;
    v.rd = rd; v.delay = delay; v.exp_addr = ea_exp; v.exp_strb = strb;
    v.exp_wdata = wdata; v.exp_data = data; v.exp_err = err;
    return v;
  endfunction

  // Reference model: works in access sizes, byte lanes and integer arithmetic.
  function automatic vec_t model(string nm, logic [7:0] op, logic [31:0] rs1, logic [31:0] imm,
                                 logic [31:0] rs2, logic [31:0] rdata, logic [4:0] rd, int delay);
    vec_t        v;
    int          ones = 0, idx = 0, size, lane;
    logic [31:0] ea;
    logic [63:0] val, span;
    ea = rs1 + imm;
    v = mk(nm, op, rs1, imm, rs2, rdata, rd, delay, ea, 4'd0, 32'd0, 32'd0, 0);
    for (int i = 0; i < 8; i++) if (op[i]) begin ones++; idx = 7 - i; end
    size = (idx == 2 || idx == 7) ? 4 : (idx == 1 || idx == 4 || idx == 6) ? 2 : 1;
    lane = int'(ea % 32'd4);
    if (ones != 1) v.exp_err = 2;
    else if ((ea % size) != 0) v.exp_err = 1;
    else begin
      v.exp_addr = (ea / 4) * 4;
      v.exp_err  = (delay >= TO) ? 3 : 0;
      if (idx >= 5) begin
        v.exp_strb = 4'(((1 << size) - 1) << lane);
        for (int b = 0; b < 4; b++) v.exp_wdata[8*b +: 8] = 8'((rs2 >> (8 * (b % size))) & 32'hFF);
      end else begin
        span = 64'd1 << (8 * size);
        val  = ({32'd0, rdata} >> (8 * lane)) & (span - 64'd1);
        if (idx < 2 && val >= (span >> 1)) val = val - span;
        v.exp_data = val[31:0];
      end
    end
    return v;
  endfunction

  task automatic busyNoise();
    ls_valid = 1'($urandom_range(0, 1));
    ls_op    = 8'($urandom);
    rs1_val  = $urandom;
    rs2_val  = $urandom;
    imm_val  = $urandom;
    rd_idx   = 5'($urandom);
  endtask

  // Entered and left at posedge+1 with the controller idle.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] ea;
    logic        done, timed_out, is_load;
    ea        = v.rs1 + v.imm;
    is_load   = |v.op[7:3];
    done      = 1'b0;
    timed_out = 1'b0;
    ls_valid = 1'b1; ls_op = v.op; rs1_val = v.rs1; imm_val = v.imm;
    rs2_val = v.rs2; rd_idx = v.rd; mem_ready = 1'b0;
    @(negedge clk_in);
    checkOutput({v.name, ":ready_idle"}, 32'(ls_ready), 32'd1);
    @(posedge clk_in); #1;
    busyNoise();
    if (v.exp_err == 1 || v.exp_err == 2) begin
      @(negedge clk_in);
      checkOutput({v.name, ":err_done"}, 32'(ls_done), 32'd1);
      checkOutput({v.name, ":err_misalign"}, 32'(err_misalign), 32'(v.exp_err == 1));
      checkOutput({v.name, ":err_illegal"}, 32'(err_illegal), 32'(v.exp_err == 2));
      checkOutput({v.name, ":err_addr"}, err_addr, v.exp_addr);
      checkOutput({v.name, ":err_no_bus"}, 32'(mem_valid), 32'd0);
      last_err_addr = v.exp_addr;
      @(posedge clk_in); #1;
    end else begin
      for (int k = 0; k < TO + 2 && !done; k++) begin
        mem_ready = (k == v.delay);
        mem_rdata = mem_ready ? v.rdata : $urandom;
        @(negedge clk_in);
        checkOutput({v.name, ":mem_valid"}, 32'(mem_valid), 32'd1);
        checkOutput({v.name, ":mem_addr"}, mem_addr, v.exp_addr);
        checkOutput({v.name, ":mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_strb));
        checkOutput({v.name, ":mem_wdata"}, mem_wdata, v.exp_wdata);
        if (mem_ready) begin
          checkOutput({v.name, ":no_err_bus"}, 32'(err_bus), 32'd0);
          done = 1'b1;
        end else if (k == TO - 1) begin
          checkOutput({v.name, ":err_bus"}, 32'(err_bus), 32'd1);
          checkOutput({v.name, ":bus_done"}, 32'(ls_done), 32'd1);
          checkOutput({v.name, ":bus_err_addr"}, err_addr, ea);
          last_err_addr = ea;
          timed_out = 1'b1;
          done = 1'b1;
        end else begin
          checkOutput({v.name, ":wait_done"}, 32'(ls_done), 32'd0);
        end
        @(posedge clk_in); #1;
        mem_ready = 1'b0;
        busyNoise();
      end
      checkOutput({v.name, ":bus_bounded"}, 32'(done), 32'd1);
      checkOutput({v.name, ":timeout_expect"}, 32'(timed_out), 32'(v.exp_err == 3));
      if (!timed_out) begin
        @(negedge clk_in);
        checkOutput({v.name, ":resp_done"}, 32'(ls_done), 32'd1);
        checkOutput({v.name, ":resp_no_bus"}, 32'(mem_valid), 32'd0);
        checkOutput({v.name, ":wb_valid"}, 32'(wb_valid), 32'(is_load && v.rd != 5'd0));
        if (is_load) begin
          checkOutput({v.name, ":wb_rd"}, 32'(wb_rd), 32'(v.rd));
          checkOutput({v.name, ":wb_data"}, wb_data, v.exp_data);
          last_wb_data = v.exp_data;
        end
        @(posedge clk_in); #1;
      end
    end
    ls_valid = 1'b0;
    @(negedge clk_in);
    checkOutput({v.name, ":ready_again"}, 32'(ls_ready), 32'd1);
    checkOutput({v.name, ":idle_done"}, 32'(ls_done), 32'd0);
    checkOutput({v.name, ":idle_no_bus"}, 32'(mem_valid), 32'd0);
    checkOutput({v.name, ":idle_wb"}, 32'(wb_valid), 32'd0);
    checkOutput({v.name, ":hold_err_addr"}, err_addr, last_err_addr);
    checkOutput({v.name, ":hold_wb_data"}, wb_data, last_wb_data);
    @(posedge clk_in); #1;
  endtask

  initial begin
    rst_n = 1'b0; ls_valid = 1'b0; ls_op = 8'd0; rs1_val = 32'd0; rs2_val = 32'd0;
    imm_val = 32'd0; rd_idx = 5'd0; mem_ready = 1'b0; mem_rdata = 32'd0;

    vecs.push_back(mk("lw",      8'h20, 32'h1000, 32'd4, 32'd0, 32'hDEADBEEF, 5'd5, 0, 32'h1004, 4'b0000, 32'd0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("lb",      8'h80, 32'h2000, 32'd3, 32'd0, 32'h80FF1234, 5'd7, 0, 32'h2000, 4'b0000, 32'd0, 32'hFFFFFF80, 0));
    vecs.push_back(mk("lbu",     8'h10, 32'h2000, 32'd3, 32'd0, 32'h80FF1234, 5'd8, 1, 32'h2000, 4'b0000, 32'd0, 32'h00000080, 0));
    vecs.push_back(mk("lh",      8'h40, 32'h2000, 32'd2, 32'd0, 32'h80FF1234, 5'd9, 0, 32'h2000, 4'b0000, 32'd0, 32'hFFFF80FF, 0));
    vecs.push_back(mk("sb_wait", 8'h04, 32'h3000, 32'd1, 32'h000000AB, 32'd0, 5'd3, 3, 32'h3000, 4'b0010, 32'hABABABAB, 32'd0, 0));
    vecs.push_back(mk("sw_mis",  8'h01, 32'h4000, 32'd2, 32'h11223344, 32'd0, 5'd0, 0, 32'h4002, 4'b0000, 32'd0, 32'd0, 1));
    vecs.push_back(mk("illegal", 8'h06, 32'h5000, 32'd0, 32'd0, 32'd0, 5'd1, 0, 32'h5000, 4'b0000, 32'd0, 32'd0, 2));
    vecs.push_back(mk("timeout", 8'h20, 32'h6000, 32'd0, 32'd0, 32'd0, 5'd2, 99, 32'h6000, 4'b0000, 32'd0, 32'd0, 3));
    vecs.push_back(mk("lhu_neg", 8'h08, 32'h7004, 32'hFFFFFFFE, 32'd0, 32'h9ABC5678, 5'd4, 2, 32'h7000, 4'b0000, 32'd0, 32'h00009ABC, 0));
    vecs.push_back(mk("lw_x0",   8'h20, 32'h0, 32'h100, 32'd0, 32'h12345678, 5'd0, 0, 32'h100, 4'b0000, 32'd0, 32'h12345678, 0));
    vecs.push_back(mk("sh_hi",   8'h02, 32'h8000, 32'd2, 32'h1234BEEF, 32'd0, 5'd6, 1, 32'h8000, 4'b1100, 32'hBEEFBEEF, 32'd0, 0));
    vecs.push_back(mk("lh_mis",  8'h40, 32'h9000, 32'd1, 32'd0, 32'd0, 5'd6, 0, 32'h9001, 4'b0000, 32'd0, 32'd0, 1));
    vecs.push_back(mk("op_zero", 8'h00, 32'hA000, 32'd4, 32'd0, 32'd0, 5'd6, 0, 32'hA004, 4'b0000, 32'd0, 32'd0, 2));

    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("reset:ls_ready", 32'(ls_ready), 32'd1);
    checkOutput("reset:mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset:ls_done", 32'(ls_done), 32'd0);
    checkOutput("reset:wb_data", wb_data, 32'd0);
    checkOutput("reset:err_addr", err_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk_in); #1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Asynchronous reset while a request is outstanding on the bus.
    ls_valid = 1'b1; ls_op = 8'h20; rs1_val = 32'hB000; imm_val = 32'd0; rd_idx = 5'd3; mem_ready = 1'b0;
    @(posedge clk_in); #1;
    ls_valid = 1'b0;
    @(negedge clk_in);
    checkOutput("rst_mid:bus_active", 32'(mem_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid:mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_mid:ls_ready", 32'(ls_ready), 32'd1);
    checkOutput("rst_mid:ls_done", 32'(ls_done), 32'd0);
    @(negedge clk_in);
    checkOutput("rst_mid:no_done", 32'(ls_done), 32'd0);
    checkOutput("rst_mid:err_addr", err_addr, 32'd0);
    checkOutput("rst_mid:wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    last_err_addr = 32'd0;
    last_wb_data  = 32'd0;
    @(posedge clk_in); #1;

    for (int n = 0; n < 60; n++) begin
      logic [7:0]  op;
      logic [31:0] rs1, imm;
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      else op = 8'd1 << $urandom_range(0, 7);
      rs1 = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        rs1 = rs1 & ~32'h3;
        imm = 32'($urandom_range(0, 3)) * 32'($urandom_range(0, 4));
      end else begin
        imm = $urandom;
      end
      applyStimulus(model("rand", op, rs1, imm, $urandom, $urandom, 5'($urandom), $urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prirv32_lsu_ctrl.md
Name: prirv32_lsu_ctrl

Overview:
- Load/store sequencer for the priRV32 execute stage.
- Accepts one decoded load/store at a time: one-hot op, rs1, imm, rs2, rd. Computes the effective address and checks alignment.
- Drives a valid/ready memory bus with byte strobes, then returns sign/zero-extended load data to writeback.
- Backpressures the EXU through ls_ready while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUS waiting for mem_ready before bus error; 0 disables timeout.
- CNT_W, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ls_valid  input  1  EXU presents a load/store
- ls_ready  output  1  controller can accept (high only in IDLE)
- ls_op  input  8  one-hot {lb,lh,lw,lbu,lhu,sb,sh,sw}, bit7=lb ... bit0=sw
- rs1_val  input  32  base register value
- rs2_val  input  32  store data register value
- imm_val  input  32  sign-extended offset
- rd_idx  input  5  load destination
- mem_valid  output  1  bus request
- mem_ready  input  1  bus completion
- mem_addr  output  32  word-aligned address
- mem_wdata  output  32  store data, lane-replicated
- mem_wstrb  output  4  byte write strobes; 0000 = read
- mem_rdata  input  32  read data, valid with mem_ready
- wb_valid  output  1  one-cycle writeback pulse
- wb_rd  output  5  writeback register
- wb_data  output  32  extended load result
- ls_done  output  1  one-cycle completion pulse, including errors
- err_misalign  output  1  one-cycle misaligned-access pulse
- err_illegal  output  1  one-cycle pulse, ls_op not one-hot
- err_bus  output  1  one-cycle timeout pulse
- err_addr  output  32  faulting effective address; holds until next error

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs 0 except ls_ready=1. Counter 0. An in-flight mem_valid drops immediately; no completion pulses.
- States: IDLE, BUS, RESP, ERR.
- IDLE:
  - ls_ready=1. On ls_valid&ls_ready, latch ea=rs1_val+imm_val (mod 2^32), op, rd, rs2.
  - ls_op not exactly one bit set -> ERR (illegal).
  - lh/lhu/sh with ea[0]=1, or lw/sw with ea[1:0]!=0 -> ERR (misalign).
  - Otherwise -> BUS.
- ERR: one cycle. Pulse ls_done plus err_illegal or err_misalign. err_addr=ea. No bus activity. Then IDLE.
- BUS:
  - mem_valid=1. mem_addr={ea[31:2],2'b00}. Addr, wdata and wstrb stay stable until mem_ready.
  - Strobes: sb 0001<<ea[1:0]; sh 0011<<ea[1:0]; sw 1111; loads 0000.
  - wdata: sb {4{rs2[7:0]}}; sh {2{rs2[15:0]}}; sw rs2; loads 0.
  - mem_ready=1 -> latch mem_rdata, go to RESP, clear counter.
  - Otherwise increment counter. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no ready: pulse err_bus+ls_done, err_addr=ea, go to IDLE next cycle.
  - mem_ready in the same cycle as timeout: ready wins.
- RESP: one cycle, mem_valid=0.
  - Loads: select byte ea[1:0] or half ea[1]. lb/lh sign-extend; lbu/lhu zero-extend; lw full word. wb_data=result, wb_rd=rd.
  - wb_valid=1 unless rd==0; wb_data/wb_rd still driven when rd==0.
  - Stores: no wb_valid.
  - ls_done=1 for both. Then IDLE.
- Latency with zero-wait bus:
  - Accept at cycle T.
  - mem_valid high in T+1, mem_ready sampled at T+1.
  - wb_valid/ls_done in T+2.
  - ls_ready high again in T+3.
  - Error paths: pulses at T+1, ls_ready at T+2.
- ls_valid while ls_ready=0 is ignored; the EXU must hold it.
- wb_data/wb_rd hold their last value when wb_valid=0.

Test Plan:
- lw, rs1=0x1000, imm=4, rd=5, mem_rdata=0xDEADBEEF, mem_ready=1 in first BUS cycle -> mem_addr=0x1004, wstrb=0000, wb_valid at T+2 with rd=5, data=0xDEADBEEF, ls_done same cycle.
- lb, ea=0x2003, rdata=0x80FF_1234 -> wb_data=0xFFFFFF80. Same with lbu -> 0x00000080. lh, ea=0x2002 -> 0xFFFF80FF.
- sb, ea=0x3001, rs2=0x000000AB, mem_ready delayed 3 cycles -> mem_addr=0x3000, wstrb=0010, wdata=0xABABABAB held stable 4 cycles; no wb_valid; ls_done 1 cycle later.
- sw, ea=0x4002 -> err_misalign+ls_done at T+1, err_addr=0x4002, mem_valid never asserts.
- ls_op=8'b0000_0110 -> err_illegal at T+1.
- TIMEOUT_CYCLES=4, mem_ready never asserted -> mem_valid high exactly 4 cycles, err_bus pulse, then IDLE.
- rst_n low mid-BUS -> mem_valid=0 immediately, ls_ready=1, no ls_done.
